// File: rtl/cpu_ctrl_pkg.sv
// ============================================================================
//  Module   : cpu_ctrl_pkg
//  Brief    : Opcode/funct codes, FSM states and datapath select encodings
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_ctrl_pkg;

    localparam logic [5:0] c_OP_RTYPE = 6'h00;
    localparam logic [5:0] c_OP_J     = 6'h02;
    localparam logic [5:0] c_OP_BEQ   = 6'h04;
    localparam logic [5:0] c_OP_BNE   = 6'h05;
    localparam logic [5:0] c_OP_ADDI  = 6'h08;
    localparam logic [5:0] c_OP_LW    = 6'h23;
    localparam logic [5:0] c_OP_SW    = 6'h2B;

    localparam logic [5:0] c_FN_MFHI  = 6'h10;
    localparam logic [5:0] c_FN_MFLO  = 6'h12;
    localparam logic [5:0] c_FN_MULT  = 6'h18;
    localparam logic [5:0] c_FN_DIV   = 6'h1A;
    localparam logic [5:0] c_FN_ADD   = 6'h20;
    localparam logic [5:0] c_FN_SUB   = 6'h22;
    localparam logic [5:0] c_FN_AND   = 6'h24;

    localparam logic [2:0] c_ALU_ADD  = 3'b001;
    localparam logic [2:0] c_ALU_SUB  = 3'b010;
    localparam logic [2:0] c_ALU_AND  = 3'b011;
    localparam logic [2:0] c_ALU_CMP  = 3'b111;

    localparam logic [1:0] c_IORD_PC     = 2'b00;
    localparam logic [1:0] c_IORD_ALUOUT = 2'b01;
    localparam logic [1:0] c_IORD_EXC    = 2'b10;

    localparam logic [2:0] c_PCSRC_JUMP   = 3'b000;
    localparam logic [2:0] c_PCSRC_ALU    = 3'b010;
    localparam logic [2:0] c_PCSRC_ALUOUT = 3'b100;
    localparam logic [2:0] c_PCSRC_EXC    = 3'b101;

    localparam logic [2:0] c_M2R_HILO   = 3'b011;
    localparam logic [2:0] c_M2R_MDR    = 3'b100;
    localparam logic [2:0] c_M2R_ALUOUT = 3'b101;

    localparam logic [2:0] c_SRCB_B      = 3'b000;
    localparam logic [2:0] c_SRCB_FOUR   = 3'b001;
    localparam logic [2:0] c_SRCB_IMM    = 3'b010;
    localparam logic [2:0] c_SRCB_BRANCH = 3'b011;

    localparam logic [1:0] c_SRCA_PC = 2'b00;
    localparam logic [1:0] c_SRCA_A  = 2'b10;

    localparam logic [1:0] c_REGDST_RT = 2'b00;
    localparam logic [1:0] c_REGDST_RD = 2'b01;

    localparam logic [1:0] c_CB_EQ = 2'b00;
    localparam logic [1:0] c_CB_NE = 2'b01;

    localparam logic [1:0] c_EC_INVALID = 2'b00;
    localparam logic [1:0] c_EC_OVF     = 2'b01;
    localparam logic [1:0] c_EC_DIV0    = 2'b10;

    typedef enum logic [4:0] {
        S_RESET      = 5'd0,
        S_FETCH      = 5'd1,
        S_FETCH_WAIT = 5'd2,
        S_DECODE     = 5'd3,
        S_EXEC_R     = 5'd4,
        S_WB_R       = 5'd5,
        S_ADDI_EX    = 5'd6,
        S_ADDI_WB    = 5'd7,
        S_MEM_ADDR   = 5'd8,
        S_LW_READ    = 5'd9,
        S_LW_WAIT    = 5'd10,
        S_LW_WB      = 5'd11,
        S_SW_WRITE   = 5'd12,
        S_BRANCH     = 5'd13,
        S_JUMP       = 5'd14,
        S_EXC_SAVE   = 5'd15,
        S_EXC_READ   = 5'd16,
        S_EXC_WAIT   = 5'd17,
        S_EXC_LOAD   = 5'd18,
        S_MULDIV_RUN = 5'd19,
        S_MULDIV_WB  = 5'd20,
        S_MF_WB      = 5'd21
    } state_e;

endpackage

`default_nettype wire

// File: rtl/cpu_control_unit_muldiv_timer.sv
// ============================================================================
//  Module   : muldiv_timer
//  Brief    : Saturating 8-bit cycle counter pacing the fixed-latency mult/div;
//             only instantiated when MULDIV_EN is defined.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module muldiv_timer #(
    parameter int CYCLES = 33
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic en,
    output logic done
);

    localparam logic [7:0] c_LAST = 8'(CYCLES - 1);

    logic [7:0] count_q;
    logic [7:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = 8'd0;
        end else if (en && (count_q != 8'hFF)) begin
            count_d = count_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= 8'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign done = (count_q >= c_LAST);

endmodule

`default_nettype wire

// File: rtl/cpu_control_unit.sv
// ============================================================================
//  Module   : cpu_control_unit
//  Brief    : Multicycle MIPS-subset main control FSM. Optional mult/div/mfhi/
//             mflo support is compiled in when MULDIV_EN is defined.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cpu_control_unit
    import cpu_ctrl_pkg::*;
#(
    parameter int MULDIV_CYCLES = 33,
    parameter int EXC_VEC_BASE  = 253
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       flag_overflow,
    input  logic       div_by_zero,
    output logic       pc_w,
    output logic       pc_write_cond,
    output logic       mem_w,
    output logic       ir_w,
    output logic       mdr_w,
    output logic       rb_w,
    output logic       reg_ab_w,
    output logic       alu_out_w,
    output logic       epc_w,
    output logic       hilo_w,
    output logic       div_or_mult,
    output logic [1:0] iord,
    output logic [1:0] reg_dst,
    output logic [1:0] cb,
    output logic [1:0] ec_ctrl,
    output logic [1:0] alu_src_a,
    output logic [2:0] alu_src_b,
    output logic [2:0] alu_control,
    output logic [2:0] pc_source,
    output logic [2:0] mem_to_reg,
    output logic [4:0] state_dbg
);

    localparam int c_unused_vec_base = EXC_VEC_BASE;

    state_e     state_q;
    state_e     state_d;
    logic [1:0] ec_q;
    logic [1:0] ec_d;

`ifdef MULDIV_EN
    logic w_md_done;

    muldiv_timer #(
        .CYCLES (MULDIV_CYCLES)
    ) u_muldiv_timer (
        .clk   (clk),
        .reset (reset),
        .clear (state_q == S_DECODE),
        .en    (state_q == S_MULDIV_RUN),
        .done  (w_md_done)
    );
`else
    logic w_unused;
    assign w_unused = div_by_zero ^ (MULDIV_CYCLES == 0);
`endif

    always_comb begin
        state_d       = state_q;
        ec_d          = ec_q;
        pc_w          = 1'b0;
        pc_write_cond = 1'b0;
        mem_w         = 1'b0;
        ir_w          = 1'b0;
        mdr_w         = 1'b0;
        rb_w          = 1'b0;
        reg_ab_w      = 1'b0;
        alu_out_w     = 1'b0;
        epc_w         = 1'b0;
        hilo_w        = 1'b0;
        div_or_mult   = 1'b0;
        iord          = 2'b00;
        reg_dst       = 2'b00;
        cb            = 2'b00;
        ec_ctrl       = 2'b00;
        alu_src_a     = 2'b00;
        alu_src_b     = 3'b000;
        alu_control   = 3'b000;
        pc_source     = 3'b000;
        mem_to_reg    = 3'b000;

        case (state_q)
            S_RESET: state_d = S_FETCH;
            S_FETCH: begin
                iord        = c_IORD_PC;
                alu_src_a   = c_SRCA_PC;
                alu_src_b   = c_SRCB_FOUR;
                alu_control = c_ALU_ADD;
                pc_source   = c_PCSRC_ALU;
                pc_w        = 1'b1;
                state_d     = S_FETCH_WAIT;
            end
            S_FETCH_WAIT: begin
                ir_w    = 1'b1;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                reg_ab_w    = 1'b1;
                alu_src_b   = c_SRCB_BRANCH;
                alu_control = c_ALU_ADD;
                alu_out_w   = 1'b1;
                ec_d        = c_EC_INVALID;
                state_d     = S_EXC_SAVE;
                case (opcode)
                    c_OP_RTYPE: begin
                        case (funct)
                            c_FN_ADD, c_FN_SUB, c_FN_AND: state_d = S_EXEC_R;
`ifdef MULDIV_EN
                            c_FN_MULT, c_FN_DIV:          state_d = S_MULDIV_RUN;
                            c_FN_MFHI, c_FN_MFLO:         state_d = S_MF_WB;
`endif
                            default:                      state_d = S_EXC_SAVE;
                        endcase
                    end
                    c_OP_ADDI:          state_d = S_ADDI_EX;
                    c_OP_LW, c_OP_SW:   state_d = S_MEM_ADDR;
                    c_OP_BEQ, c_OP_BNE: state_d = S_BRANCH;
                    c_OP_J:             state_d = S_JUMP;
                    default:            state_d = S_EXC_SAVE;
                endcase
            end
            S_EXEC_R: begin
                alu_src_a   = c_SRCA_A;
                alu_src_b   = c_SRCB_B;
                alu_out_w   = 1'b1;
                alu_control = (funct == c_FN_SUB) ? c_ALU_SUB :
                              (funct == c_FN_AND) ? c_ALU_AND : c_ALU_ADD;
                // A logical AND cannot overflow, so the flag is only honoured for add/sub.
                if (flag_overflow && (funct != c_FN_AND)) begin
                    ec_d    = c_EC_OVF;
                    state_d = S_EXC_SAVE;
                end else begin
                    state_d = S_WB_R;
                end
            end
            S_WB_R: begin
                reg_dst    = c_REGDST_RD;
                mem_to_reg = c_M2R_ALUOUT;
                rb_w       = 1'b1;
                state_d    = S_FETCH;
            end
            S_ADDI_EX: begin
                alu_src_a   = c_SRCA_A;
                alu_src_b   = c_SRCB_IMM;
                alu_control = c_ALU_ADD;
                alu_out_w   = 1'b1;
                if (flag_overflow) begin
                    ec_d    = c_EC_OVF;
                    state_d = S_EXC_SAVE;
                end else begin
                    state_d = S_ADDI_WB;
                end
            end
            S_ADDI_WB: begin
                reg_dst    = c_REGDST_RT;
                mem_to_reg = c_M2R_ALUOUT;
                rb_w       = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEM_ADDR: begin
                alu_src_a   = c_SRCA_A;
                alu_src_b   = c_SRCB_IMM;
                alu_control = c_ALU_ADD;
                alu_out_w   = 1'b1;
                state_d     = (opcode == c_OP_LW) ? S_LW_READ : S_SW_WRITE;
            end
            S_LW_READ: begin
                iord    = c_IORD_ALUOUT;
                state_d = S_LW_WAIT;
            end
            S_LW_WAIT: begin
                mdr_w   = 1'b1;
                state_d = S_LW_WB;
            end
            S_LW_WB: begin
                mem_to_reg = c_M2R_MDR;
                reg_dst    = c_REGDST_RT;
                rb_w       = 1'b1;
                state_d    = S_FETCH;
            end
            S_SW_WRITE: begin
                iord    = c_IORD_ALUOUT;
                mem_w   = 1'b1;
                state_d = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a     = c_SRCA_A;
                alu_src_b     = c_SRCB_B;
                alu_control   = c_ALU_CMP;
                pc_source     = c_PCSRC_ALUOUT;
                pc_write_cond = 1'b1;
                cb            = (opcode == c_OP_BNE) ? c_CB_NE : c_CB_EQ;
                state_d       = S_FETCH;
            end
            S_JUMP: begin
                pc_source = c_PCSRC_JUMP;
                pc_w      = 1'b1;
                state_d   = S_FETCH;
            end
            // The cause latched on entry is presented for the whole 4-cycle sequence.
            S_EXC_SAVE: begin
                epc_w   = 1'b1;
                ec_ctrl = ec_q;
                state_d = S_EXC_READ;
            end
            S_EXC_READ: begin
                iord    = c_IORD_EXC;
                ec_ctrl = ec_q;
                state_d = S_EXC_WAIT;
            end
            S_EXC_WAIT: begin
                mdr_w   = 1'b1;
                ec_ctrl = ec_q;
                state_d = S_EXC_LOAD;
            end
            S_EXC_LOAD: begin
                pc_source = c_PCSRC_EXC;
                pc_w      = 1'b1;
                ec_ctrl   = ec_q;
                state_d   = S_FETCH;
            end
`ifdef MULDIV_EN
            S_MULDIV_RUN: begin
                if (w_md_done) begin
                    state_d = S_MULDIV_WB;
                end
            end
            S_MULDIV_WB: begin
                div_or_mult = (funct == c_FN_MULT);
                if ((funct == c_FN_DIV) && div_by_zero) begin
                    ec_d    = c_EC_DIV0;
                    state_d = S_EXC_SAVE;
                end else begin
                    hilo_w  = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_MF_WB: begin
                mem_to_reg = c_M2R_HILO;
                reg_dst    = c_REGDST_RD;
                rb_w       = 1'b1;
                state_d    = S_FETCH;
            end
`endif
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_RESET;
            ec_q    <= 2'b00;
        end else begin
            state_q <= state_d;
            ec_q    <= ec_d;
        end
    end

    assign state_dbg = state_q;

endmodule

`default_nettype wire

// File: tb/tb_cpu_control_unit.sv
// ============================================================================
//  Module   : tb_cpu_control_unit
//  Brief    : Random instruction stream against a per-instruction state-path
//             and per-state control-word reference model.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cpu_control_unit;
    import cpu_ctrl_pkg::*;

`ifdef MULDIV_EN
    localparam bit c_MD = 1'b1;
`else
    localparam bit c_MD = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       flag_overflow;
    logic       div_by_zero;
    logic       pc_w, pc_write_cond, mem_w, ir_w, mdr_w, rb_w, reg_ab_w;
    logic       alu_out_w, epc_w, hilo_w, div_or_mult;
    logic [1:0] iord, reg_dst, cb, ec_ctrl, alu_src_a;
    logic [2:0] alu_src_b, alu_control, pc_source, mem_to_reg;
    logic [4:0] state_dbg;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    cpu_control_unit #(
        .MULDIV_CYCLES (33),
        .EXC_VEC_BASE  (253)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .opcode        (opcode),
        .funct         (funct),
        .flag_overflow (flag_overflow),
        .div_by_zero   (div_by_zero),
        .pc_w          (pc_w),
        .pc_write_cond (pc_write_cond),
        .mem_w         (mem_w),
        .ir_w          (ir_w),
        .mdr_w         (mdr_w),
        .rb_w          (rb_w),
        .reg_ab_w      (reg_ab_w),
        .alu_out_w     (alu_out_w),
        .epc_w         (epc_w),
        .hilo_w        (hilo_w),
        .div_or_mult   (div_or_mult),
        .iord          (iord),
        .reg_dst       (reg_dst),
        .cb            (cb),
        .ec_ctrl       (ec_ctrl),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_control   (alu_control),
        .pc_source     (pc_source),
        .mem_to_reg    (mem_to_reg),
        .state_dbg     (state_dbg)
    );

    logic [32:0] w_obs;
    assign w_obs = {pc_w, pc_write_cond, mem_w, ir_w, mdr_w, rb_w, reg_ab_w,
                    alu_out_w, epc_w, hilo_w, div_or_mult, iord, reg_dst, cb,
                    ec_ctrl, alu_src_a, alu_src_b, alu_control, pc_source, mem_to_reg};

    task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Control word each state must present, written straight from the state table.
    function automatic logic [32:0] exp_out(state_e s, logic [5:0] op, logic [5:0] fn,
                                            logic [1:0] ec, logic dbz);
        logic pcw, pcc, mw, irw, mdw, rbw, abw, aow, epw, hlw, dom;
        logic [1:0] io, rd, cbv, ecv, sa;
        logic [2:0] sb, ac, ps, m2r;
        {pcw, pcc, mw, irw, mdw, rbw, abw, aow, epw, hlw, dom} = '0;
        {io, rd, cbv, ecv, sa} = '0;
        {sb, ac, ps, m2r} = '0;
        case (s)
            S_FETCH:      begin sb = 3'b001; ac = 3'b001; ps = 3'b010; pcw = 1'b1; end
            S_FETCH_WAIT: irw = 1'b1;
            S_DECODE:     begin abw = 1'b1; sb = 3'b011; ac = 3'b001; aow = 1'b1; end
            S_EXEC_R: begin
                sa = 2'b10; aow = 1'b1;
                ac = (fn == 6'h22) ? 3'b010 : (fn == 6'h24) ? 3'b011 : 3'b001;
            end
            S_WB_R:       begin rd = 2'b01; m2r = 3'b101; rbw = 1'b1; end
            S_ADDI_EX:    begin sa = 2'b10; sb = 3'b010; ac = 3'b001; aow = 1'b1; end
            S_ADDI_WB:    begin m2r = 3'b101; rbw = 1'b1; end
            S_MEM_ADDR:   begin sa = 2'b10; sb = 3'b010; ac = 3'b001; aow = 1'b1; end
            S_LW_READ:    io = 2'b01;
            S_LW_WAIT:    mdw = 1'b1;
            S_LW_WB:      begin m2r = 3'b100; rbw = 1'b1; end
            S_SW_WRITE:   begin io = 2'b01; mw = 1'b1; end
            S_BRANCH: begin
                sa = 2'b10; ac = 3'b111; ps = 3'b100; pcc = 1'b1;
                cbv = (op == 6'h05) ? 2'b01 : 2'b00;
            end
            S_JUMP:       pcw = 1'b1;
            S_EXC_SAVE:   begin epw = 1'b1; ecv = ec; end
            S_EXC_READ:   begin io = 2'b10; ecv = ec; end
            S_EXC_WAIT:   begin mdw = 1'b1; ecv = ec; end
            S_EXC_LOAD:   begin ps = 3'b101; pcw = 1'b1; ecv = ec; end
            S_MULDIV_WB: begin
                dom = (fn == 6'h18);
                hlw = !((fn == 6'h1A) && dbz);
            end
            S_MF_WB:      begin m2r = 3'b011; rd = 2'b01; rbw = 1'b1; end
            default: ;
        endcase
        return {pcw, pcc, mw, irw, mdw, rbw, abw, aow, epw, hlw, dom,
                io, rd, cbv, ecv, sa, sb, ac, ps, m2r};
    endfunction

    state_e     q_path[$];
    logic [1:0] q_ec;

    task automatic push_exc(input logic [1:0] cause);
        q_ec = cause;
        q_path.push_back(S_EXC_SAVE);
        q_path.push_back(S_EXC_READ);
        q_path.push_back(S_EXC_WAIT);
        q_path.push_back(S_EXC_LOAD);
    endtask

    // Expected state sequence of one instruction, decided by its class and flags.
    task automatic build_path(input logic [5:0] op, input logic [5:0] fn,
                              input logic ovf, input logic dbz);
        q_path.delete();
        q_ec = 2'b00;
        q_path.push_back(S_FETCH);
        q_path.push_back(S_FETCH_WAIT);
        q_path.push_back(S_DECODE);
        if (op == 6'h00 && (fn == 6'h20 || fn == 6'h22)) begin
            q_path.push_back(S_EXEC_R);
            if (ovf) push_exc(2'b01); else q_path.push_back(S_WB_R);
        end else if (op == 6'h00 && fn == 6'h24) begin
            q_path.push_back(S_EXEC_R);
            q_path.push_back(S_WB_R);
        end else if (c_MD && op == 6'h00 && (fn == 6'h18 || fn == 6'h1A)) begin
            repeat (33) q_path.push_back(S_MULDIV_RUN);
            q_path.push_back(S_MULDIV_WB);
            if (fn == 6'h1A && dbz) push_exc(2'b10);
        end else if (c_MD && op == 6'h00 && (fn == 6'h10 || fn == 6'h12)) begin
            q_path.push_back(S_MF_WB);
        end else if (op == 6'h08) begin
            q_path.push_back(S_ADDI_EX);
            if (ovf) push_exc(2'b01); else q_path.push_back(S_ADDI_WB);
        end else if (op == 6'h23) begin
            q_path.push_back(S_MEM_ADDR);
            q_path.push_back(S_LW_READ);
            q_path.push_back(S_LW_WAIT);
            q_path.push_back(S_LW_WB);
        end else if (op == 6'h2B) begin
            q_path.push_back(S_MEM_ADDR);
            q_path.push_back(S_SW_WRITE);
        end else if (op == 6'h04 || op == 6'h05) begin
            q_path.push_back(S_BRANCH);
        end else if (op == 6'h02) begin
            q_path.push_back(S_JUMP);
        end else begin
            push_exc(2'b00);
        end
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) begin
            @(posedge clk);
            #2;
            check_value("rst_state", 64'(state_dbg), 64'(S_RESET));
            check_value("rst_outs", 64'(w_obs), 64'd0);
        end
        reset = 1'b0;
    endtask

    // Flags are random except at the cycle where the instruction consults them.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                             input logic ovf, input logic dbz, input int abort_at);
        opcode = op;
        funct  = fn;
        build_path(op, fn, ovf, dbz);
        for (int i = 0; i < q_path.size(); i++) begin
            @(posedge clk);
            #1;
            flag_overflow = (i == 3)  ? ovf : 1'($urandom);
            div_by_zero   = (i == 36) ? dbz : 1'($urandom);
            #1;
            check_value($sformatf("state op%0h fn%0h @%0d", op, fn, i),
                        64'(state_dbg), 64'(q_path[i]));
            check_value($sformatf("ctrl %s op%0h fn%0h", q_path[i].name(), op, fn),
                        64'(w_obs), 64'(exp_out(q_path[i], op, fn, q_ec, div_by_zero)));
            if (i == abort_at) begin
                do_reset(2);
                return;
            end
        end
    endtask

    logic [5:0] r_ops[16] = '{6'h00, 6'h00, 6'h00, 6'h08, 6'h23, 6'h2B, 6'h04, 6'h05,
                              6'h02, 6'h00, 6'h00, 6'h00, 6'h00, 6'h3F, 6'h00, 6'h01};
    logic [5:0] r_fns[16] = '{6'h20, 6'h22, 6'h24, 6'h11, 6'h05, 6'h07, 6'h00, 6'h00,
                              6'h00, 6'h18, 6'h1A, 6'h10, 6'h12, 6'h00, 6'h3F, 6'h20};

    initial begin
        reset         = 1'b1;
        opcode        = 6'h00;
        funct         = 6'h00;
        flag_overflow = 1'b0;
        div_by_zero   = 1'b0;
        do_reset(2);

        run_instr(6'h00, 6'h20, 1'b0, 1'b0, -1);
        run_instr(6'h23, 6'h00, 1'b0, 1'b0, -1);
        run_instr(6'h04, 6'h00, 1'b0, 1'b0, -1);
        run_instr(6'h05, 6'h00, 1'b0, 1'b0, -1);
        run_instr(6'h08, 6'h00, 1'b1, 1'b0, -1);
        run_instr(6'h3F, 6'h00, 1'b0, 1'b0, -1);
        run_instr(6'h00, 6'h1A, 1'b0, 1'b1, -1);
        run_instr(6'h00, 6'h18, 1'b0, 1'b1, -1);
        run_instr(6'h00, 6'h10, 1'b0, 1'b0, -1);
        run_instr(6'h00, 6'h22, 1'b1, 1'b0, -1);
        run_instr(6'h00, 6'h24, 1'b1, 1'b0, -1);
        run_instr(6'h2B, 6'h00, 1'b0, 1'b0, -1);
        run_instr(6'h02, 6'h00, 1'b0, 1'b0, -1);
        run_instr(6'h00, 6'h3F, 1'b0, 1'b0, -1);
        run_instr(6'h23, 6'h00, 1'b0, 1'b0, 5);

        for (int k = 0; k < 40; k++) begin
            int sel;
            sel = int'($urandom_range(15, 0));
            run_instr(r_ops[sel], r_fns[sel], 1'($urandom), 1'($urandom), -1);
        end

        @(posedge clk);
        #2;
        check_value("final_fetch", 64'(state_dbg), 64'(S_FETCH));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
